fifo_stream_reader: RTL and testbench

//  Read-side consumer for the fifo block. Pops words through the fifo's r_ready/fifo_empty/data_out

---
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the fifo block: pops head words into a 2-entry buffer and
// presents them as a framed valid/ready stream (m_last every PKT_LEN beats).
module fifo_stream_reader #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             r_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [WIDTH-1:0]  mem_q [2];
    logic [WIDTH-1:0]  mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              pkt_done_q, pkt_done_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic pop;
    logic retire;

    // Pop permission depends only on registered occupancy, never on m_ready.
    assign r_ready  = reset && en && !fifo_empty && (occ_q != 2'd2);
    assign pop      = r_ready;
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = mem_q[rd_ptr_q];
    assign m_last   = m_valid && (beat_cnt_q == LAST_BEAT);
    assign retire   = m_valid && m_ready;
    assign pkt_done = pkt_done_q;
    assign pkt_cnt  = pkt_cnt_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        beat_cnt_d = beat_cnt_q;
        pkt_done_d = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;

        if (pop) begin
            mem_d[wr_ptr_q] = fifo_data;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (retire) begin
            rd_ptr_d = ~rd_ptr_q;
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = '0;
                pkt_done_d = 1'b1;
                pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end

        case ({pop, retire})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Reset discards buffered words; the fifo itself keeps its contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            beat_cnt_q <= '0;
            pkt_done_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_done_q <= pkt_done_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a queue-based fifo and stream reference model,
// a directed vector table, hand-written corner sequences and a randomized soak.
module tb_fifo_stream_reader;

    localparam int WIDTH   = 32;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 16;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct {
        logic             rstN;
        logic             en;
        logic             mReady;
        int               push;
        logic             expRReady;
        logic             expMValid;
        logic             chkData;
        word_t            expMData;
        logic             expMLast;
        logic             expPktDone;
        logic [CNT_W-1:0] expPktCnt;
    } vector_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             fifo_empty;
    word_t            fifo_data;
    logic             r_ready;
    logic             m_valid;
    logic             m_ready;
    word_t            m_data;
    logic             m_last;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .r_ready    (r_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_done   (pkt_done),
        .pkt_cnt    (pkt_cnt)
    );

    // Reference model: fifo contents, words held by the reader, packet position.
    word_t            fifoQ[$];
    word_t            bufQ[$];
    word_t            deliveredQ[$];
    int               beatNum = 0;
    logic             expPktDone = 1'b0;
    logic [CNT_W-1:0] expPktCnt = '0;
    logic             freshReset = 1'b1;
    int               checks = 0;
    int               passes = 0;
    word_t            nextWord = '0;

    task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic driveInputs(input logic rstV, input logic enV, input logic mrV);
        reset      = rstV;
        en         = enV;
        m_ready    = mrV;
        fifo_empty = (fifoQ.size() == 0);
        fifo_data  = (fifoQ.size() > 0) ? fifoQ[0] : '0;
    endtask

    task automatic checkOutput();
        logic expValid;
        expValid = (bufQ.size() > 0);
        compare("r_ready", 64'(r_ready),
                64'(reset && en && (fifoQ.size() > 0) && (bufQ.size() < 2)));
        compare("m_valid", 64'(m_valid), 64'(expValid));
        compare("m_last", 64'(m_last), 64'(expValid && (beatNum == PKT_LEN - 1)));
        compare("pkt_done", 64'(pkt_done), 64'(expPktDone));
        compare("pkt_cnt", 64'(pkt_cnt), 64'(expPktCnt));
        if (expValid) compare("m_data", 64'(m_data), 64'(bufQ[0]));
        else if (freshReset) compare("m_data_reset", 64'(m_data), 64'd0);
    endtask

    task automatic applyStimulus(input logic rstV, input logic enV, input logic mrV);
        driveInputs(rstV, enV, mrV);
        #1;
        checkOutput();
    endtask

    // Advance one clock, updating the model from what the reader was asked to do.
    task automatic stepClock();
        logic  rstV, expPop, expHs, actPop;
        word_t head;
        rstV   = reset;
        expPop = reset && en && (fifoQ.size() > 0) && (bufQ.size() < 2);
        expHs  = (bufQ.size() > 0) && m_ready;
        actPop = r_ready && !fifo_empty;
        head   = (fifoQ.size() > 0) ? fifoQ[0] : '0;
        if (m_valid && m_ready) deliveredQ.push_back(m_data);
        @(posedge clk);
        if (!rstV) begin
            bufQ.delete();
            beatNum    = 0;
            expPktDone = 1'b0;
            expPktCnt  = '0;
            freshReset = 1'b1;
        end else begin
            expPktDone = 1'b0;
            if (expHs) begin
                void'(bufQ.pop_front());
                if (beatNum == PKT_LEN - 1) begin
                    beatNum    = 0;
                    expPktDone = 1'b1;
                    expPktCnt  = expPktCnt + 1'b1;
                end else begin
                    beatNum++;
                end
            end
            if (expPop) begin
                bufQ.push_back(head);
                freshReset = 1'b0;
            end
        end
        if (actPop && fifoQ.size() > 0) void'(fifoQ.pop_front());
        @(negedge clk);
    endtask

    task automatic cycle(input logic rstV, input logic enV, input logic mrV);
        applyStimulus(rstV, enV, mrV);
        stepClock();
    endtask

    vector_t vecs[13];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0, 16'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 16'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 16'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd1};

        driveInputs(1'b0, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 13; i++) begin
            for (int p = 0; p < vecs[i].push; p++) begin
                fifoQ.push_back(nextWord);
                nextWord = nextWord + 1'b1;
            end
            applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].mReady);
            compare($sformatf("vec%0d_r_ready", i), 64'(r_ready), 64'(vecs[i].expRReady));
            compare($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].expMValid));
            if (vecs[i].chkData)
                compare($sformatf("vec%0d_m_data", i), 64'(m_data), 64'(vecs[i].expMData));
            compare($sformatf("vec%0d_m_last", i), 64'(m_last), 64'(vecs[i].expMLast));
            compare($sformatf("vec%0d_pkt_done", i), 64'(pkt_done), 64'(vecs[i].expPktDone));
            compare($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(vecs[i].expPktCnt));
            stepClock();
        end

        $display("[TB] back-pressure with full buffer");
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) fifoQ.push_back(word_t'(k));
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1, 1'b0);
        compare("bp_fifo_left", 64'(fifoQ.size()), 64'd3);
        deliveredQ.delete();
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b1, 1'b1);
        compare("bp_delivered", 64'(deliveredQ.size()), 64'd5);
        for (int k = 0; k < 5 && k < deliveredQ.size(); k++)
            compare($sformatf("bp_word%0d", k), 64'(deliveredQ[k]), 64'(k));

        $display("[TB] enable toggle mid-packet");
        cycle(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) fifoQ.push_back(word_t'(32'h20 + k));
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b1);
        compare("en_off_fifo_left", 64'(fifoQ.size()), 64'd1);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 1'b1);
        compare("en_on_fifo_left", 64'(fifoQ.size()), 64'd0);
        compare("en_pkt_cnt", 64'(pkt_cnt), 64'd1);

        $display("[TB] reset with two words buffered");
        cycle(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) fifoQ.push_back(word_t'(32'h30 + k));
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("rst_m_valid", 64'(m_valid), 64'd0);
        compare("rst_m_data", 64'(m_data), 64'd0);
        compare("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        stepClock();
        fifoQ.push_back(32'h36);
        fifoQ.push_back(32'h37);
        deliveredQ.delete();
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b1, 1'b1);
        compare("rst_delivered", 64'(deliveredQ.size()), 64'd4);
        compare("rst_pkt_cnt_after", 64'(pkt_cnt), 64'd1);

        $display("[TB] randomized soak");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(1, 0) == 1 && fifoQ.size() < 16) fifoQ.push_back(word_t'($urandom));
            cycle(($urandom_range(99, 0) != 0), ($urandom_range(3, 0) != 0),
                  ($urandom_range(9, 0) < 6));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
